// File: rtl/conv.sv
// Three-layer CNN engine: 3x3 conv (two kernels) + bias + ReLU, 2x2 max-pool,
// and interleaved flatten, through one image ROM port and one result-memory port.
module conv (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    output logic        busy,
    output logic [11:0] iaddr,
    input  logic [19:0] idata,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic [19:0] cdata_wr,
    output logic        crd,
    output logic [11:0] caddr_rd,
    input  logic [19:0] cdata_rd,
    output logic [2:0]  csel
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_L0   = 2'd1;
    localparam logic [1:0] S_L1   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [39:0] B0 = {4'h0, 20'h01310, 16'h0};
    localparam logic [39:0] B1 = {4'hF, 20'hF7295, 16'h0};

    function automatic logic [19:0] kern(input logic k, input logic [3:0] t);
        logic [19:0] v;
        v = '0;
        case ({k, t})
            5'h00: v = 20'h0A89E;
            5'h01: v = 20'h092D5;
            5'h02: v = 20'h06D43;
            5'h03: v = 20'h01004;
            5'h04: v = 20'hF8F71;
            5'h05: v = 20'hF6E54;
            5'h06: v = 20'hFA6D7;
            5'h07: v = 20'hFC834;
            5'h08: v = 20'hFAC19;
            5'h10: v = 20'hFDB55;
            5'h11: v = 20'h02992;
            5'h12: v = 20'hFC994;
            5'h13: v = 20'h050FD;
            5'h14: v = 20'h02F20;
            5'h15: v = 20'h0202D;
            5'h16: v = 20'h03BD7;
            5'h17: v = 20'hFD369;
            5'h18: v = 20'h05E68;
            default: v = '0;
        endcase
        return v;
    endfunction

    // a holds acc[35:15]; round half up, then clamp negatives to zero
    function automatic logic [19:0] rnd_relu(input logic [20:0] a);
        logic [19:0] v;
        v = a[20:1] + {19'b0, a[0]};
        return v[19] ? 20'h0 : v;
    endfunction

    function automatic logic [39:0] mul(input logic [19:0] a, input logic [19:0] b);
        return 40'($signed({{20{a[19]}}, a}) * $signed({{20{b[19]}}, b}));
    endfunction

    logic [1:0]  state_q, state_d;
    logic [12:0] pix_q, pix_d;
    logic [3:0]  tap_q, tap_d;
    logic [39:0] acc0_q, acc0_d, acc1_q, acc1_d;
    logic [19:0] res0_q, res0_d, res1_q, res1_d;
    logic [9:0]  o_q, o_d;
    logic        k_q, k_d;
    logic [2:0]  st_q, st_d;
    logic [19:0] max_q, max_d;

    logic [1:0]  tr, tc;
    logic [6:0]  ra, ca;
    logic        inb;
    logic [19:0] pix_s;
    logic [39:0] sum0, sum1;

    always_comb begin
        tr = 2'd0;
        tc = 2'd0;
        case (tap_q)
            4'd1: tc = 2'd1;
            4'd2: tc = 2'd2;
            4'd3: tr = 2'd1;
            4'd4: begin tr = 2'd1; tc = 2'd1; end
            4'd5: begin tr = 2'd1; tc = 2'd2; end
            4'd6: tr = 2'd2;
            4'd7: begin tr = 2'd2; tc = 2'd1; end
            4'd8: begin tr = 2'd2; tc = 2'd2; end
            default: ;
        endcase
    end

    // bit 6 set means the neighbour fell off either edge (wrap below 0 or 64)
    assign ra    = {1'b0, pix_q[11:6]} + {5'b0, tr} - 7'd1;
    assign ca    = {1'b0, pix_q[5:0]} + {5'b0, tc} - 7'd1;
    assign inb   = (state_q == S_L0) && !pix_q[12] && !ra[6] && !ca[6];
    assign pix_s = inb ? idata : 20'h0;
    assign sum0  = ((tap_q == 4'd0) ? B0 : acc0_q) + mul(pix_s, kern(1'b0, tap_q));
    assign sum1  = ((tap_q == 4'd0) ? B1 : acc1_q) + mul(pix_s, kern(1'b1, tap_q));

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        tap_d   = tap_q;
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        o_d     = o_q;
        k_d     = k_q;
        st_d    = st_q;
        max_d   = max_q;
        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    state_d = S_L0;
                    pix_d   = '0;
                    tap_d   = '0;
                end
            end
            S_L0: begin
                if (pix_q[12]) begin
                    // drain cycles flush the last pixel's two writes
                    tap_d = tap_q + 4'd1;
                    if (tap_q == 4'd1) begin
                        state_d = S_L1;
                        o_d     = '0;
                        k_d     = 1'b0;
                        st_d    = '0;
                    end
                end else begin
                    acc0_d = sum0;
                    acc1_d = sum1;
                    tap_d  = tap_q + 4'd1;
                    if (tap_q == 4'd8) begin
                        res0_d = rnd_relu(sum0[35:15]);
                        res1_d = rnd_relu(sum1[35:15]);
                        tap_d  = '0;
                        pix_d  = pix_q + 13'd1;
                    end
                end
            end
            S_L1: begin
                st_d = st_q + 3'd1;
                if (st_q < 3'd4) begin
                    if (st_q == 3'd0 || $signed(cdata_rd) > $signed(max_q))
                        max_d = cdata_rd;
                end
                if (st_q == 3'd5) begin
                    st_d = '0;
                    k_d  = ~k_q;
                    if (k_q) begin
                        o_d = o_q + 10'd1;
                        if (o_q == 10'd1023)
                            state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            tap_q   <= '0;
            acc0_q  <= '0;
            acc1_q  <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            o_q     <= '0;
            k_q     <= 1'b0;
            st_q    <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            tap_q   <= tap_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            o_q     <= o_d;
            k_q     <= k_d;
            st_q    <= st_d;
            max_q   <= max_d;
        end
    end

    always_comb begin
        busy     = (state_q == S_L0) || (state_q == S_L1);
        iaddr    = '0;
        cwr      = 1'b0;
        caddr_wr = '0;
        cdata_wr = '0;
        crd      = 1'b0;
        caddr_rd = '0;
        csel     = 3'b000;
        if (state_q == S_L0) begin
            if (inb)
                iaddr = {ra[5:0], ca[5:0]};
            // previous pixel's results go out during the first two taps
            if (pix_q != 13'd0 && tap_q < 4'd2) begin
                cwr      = 1'b1;
                csel     = tap_q[0] ? 3'b010 : 3'b001;
                caddr_wr = pix_q[11:0] - 12'd1;
                cdata_wr = tap_q[0] ? res1_q : res0_q;
            end
        end else if (state_q == S_L1) begin
            if (st_q < 3'd4) begin
                crd      = 1'b1;
                csel     = k_q ? 3'b010 : 3'b001;
                caddr_rd = {o_q[9:5], st_q[1], o_q[4:0], st_q[0]};
            end else if (st_q == 3'd4) begin
                cwr      = 1'b1;
                csel     = k_q ? 3'b100 : 3'b011;
                caddr_wr = {2'b00, o_q};
                cdata_wr = max_q;
            end else begin
                cwr      = 1'b1;
                csel     = 3'b101;
                caddr_wr = {1'b0, o_q, k_q};
                cdata_wr = max_q;
            end
        end
    end
endmodule

// File: tb/tb_conv.sv
// Scoreboard bench for conv: golden write stream queued per run, popped on each
// DUT write; covers reset, handshake, padding, abort/restart and random images.
module tb_conv;
    logic        clk = 1'b0;
    logic        reset, ready, busy, cwr, crd;
    logic [11:0] iaddr, caddr_wr, caddr_rd;
    logic [19:0] idata, cdata_wr, cdata_rd;
    logic [2:0]  csel;

    always #5 clk = ~clk;

    conv dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd), .csel(csel)
    );

    logic signed [19:0] img [0:4095];
    logic [19:0] mem [1:5][0:4095];

    assign idata    = img[iaddr];
    assign cdata_rd = (csel == 3'd1 || csel == 3'd2) ? mem[csel][caddr_rd] : 20'h0;

    always @(posedge clk)
        if (cwr && csel >= 3'd1 && csel <= 3'd5)
            mem[csel][caddr_wr] <= cdata_wr;

    typedef struct packed {
        logic [2:0]  sel;
        logic [11:0] addr;
        logic [19:0] data;
    } wr_t;

    wr_t q[$];
    int total = 0;
    int bad = 0;
    int wcnt = 0;

    logic signed [19:0] ks [0:1][0:8];
    logic signed [19:0] bias [0:1];
    logic [19:0] g0 [0:1][0:4095];
    logic [63:0] outs;

    assign outs = {2'b0, busy, cwr, crd, csel, iaddr, caddr_wr, caddr_rd, cdata_wr};

    function automatic logic [19:0] golden(int k, int r, int c);
        longint acc;
        logic [63:0] a;
        logic [19:0] v;
        acc = longint'(bias[k]) * 65536;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (r + dr >= 0 && r + dr < 64 && c + dc >= 0 && c + dc < 64)
                    acc += longint'(img[(r + dr) * 64 + c + dc]) *
                           longint'(ks[k][(dr + 1) * 3 + dc + 1]);
        a = acc;
        v = a[35:16] + {19'b0, a[15]};
        return v[19] ? 20'h0 : v;
    endfunction

    task automatic build_expect();
        logic [19:0] m, x;
        int base;
        q.delete();
        for (int p = 0; p < 4096; p++)
            for (int k = 0; k < 2; k++) begin
                g0[k][p] = golden(k, p / 64, p % 64);
                q.push_back(wr_t'{sel: 3'(k + 1), addr: 12'(p), data: g0[k][p]});
            end
        for (int o = 0; o < 1024; o++)
            for (int k = 0; k < 2; k++) begin
                base = (2 * (o / 32)) * 64 + 2 * (o % 32);
                m = g0[k][base];
                x = g0[k][base + 1];
                if ($signed(x) > $signed(m)) m = x;
                x = g0[k][base + 64];
                if ($signed(x) > $signed(m)) m = x;
                x = g0[k][base + 65];
                if ($signed(x) > $signed(m)) m = x;
                q.push_back(wr_t'{sel: 3'(k + 3), addr: 12'(o), data: m});
                q.push_back(wr_t'{sel: 3'd5, addr: 12'(2 * o + k), data: m});
            end
    endtask

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (cwr) begin
            wcnt++;
            total++;
            assert (csel != 3'd0 && !crd) else begin
                bad++;
                $error("FAIL proto: csel=%0d crd=%0b expected csel!=0 crd=0", csel, crd);
            end
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL extra_wr: sel=%0d addr=%0d data=%h expected no write",
                       csel, caddr_wr, cdata_wr);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                total++;
                assert ({csel, caddr_wr, cdata_wr} === e) else begin
                    bad++;
                    $error("FAIL wr%0d: got sel=%0d addr=%0d data=%h expected sel=%0d addr=%0d data=%h",
                           wcnt, csel, caddr_wr, cdata_wr, e.sel, e.addr, e.data);
                end
            end
        end
    endtask

    initial begin
        int n;
        ks[0] = '{20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
                  20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19};
        ks[1] = '{20'hFDB55, 20'h02992, 20'hFC994, 20'h050FD, 20'h02F20,
                  20'h0202D, 20'h03BD7, 20'hFD369, 20'h05E68};
        bias[0] = 20'h01310;
        bias[1] = 20'hF7295;

        // run 1: single 1.0 pixel at (0,0), ready held through reset, aborted in L1
        reset = 1'b1;
        ready = 1'b1;
        for (int p = 0; p < 4096; p++) img[p] = 20'h0;
        img[0] = 20'h10000;
        build_expect();
        wcnt = 0;
        repeat (3) tick();
        chk("reset_outs", outs, 64'h0);
        reset = 1'b0;
        tick();
        chk("busy_rise", {63'h0, busy}, 64'h1);
        ready = 1'b0;
        n = 0;
        while (wcnt < 8232 && n < 40000) begin
            tick();
            n++;
        end
        chk("run1_in_l1", {63'h0, wcnt >= 8232}, 64'h1);
        chk("run1_busy", {63'h0, busy}, 64'h1);
        reset = 1'b1;
        tick();
        chk("abort_outs", outs, 64'h0);
        chk("corner_k0", {44'h0, mem[1][0]}, 64'h0);
        chk("diag_k0", {44'h0, mem[1][65]}, 64'h0BBAE);
        chk("right_k0", {44'h0, mem[1][1]}, 64'h02314);
        chk("below_k0", {44'h0, mem[1][64]}, 64'h0A5E5);
        chk("zero_k0", {44'h0, mem[1][4095]}, 64'h01310);
        chk("zero_k1", {44'h0, mem[2][4095]}, 64'h0);
        chk("l1_k0", {44'h0, mem[3][5]}, 64'h01310);
        chk("l1_k1", {44'h0, mem[4][5]}, 64'h0);
        chk("l2_even", {44'h0, mem[5][10]}, 64'h01310);
        chk("l2_odd", {44'h0, mem[5][11]}, 64'h0);

        // run 2: random image, single-cycle ready pulse, full run
        tick();
        for (int p = 0; p < 4096; p++) img[p] = 20'($urandom);
        build_expect();
        wcnt = 0;
        reset = 1'b0;
        ready = 1'b1;
        tick();
        chk("restart_busy", {63'h0, busy}, 64'h1);
        ready = 1'b0;
        n = 0;
        while (busy && n < 60000) begin
            tick();
            n++;
        end
        chk("run2_done", {63'h0, busy}, 64'h0);
        chk("run2_writes", 64'(wcnt), 64'd12288);
        chk("run2_queue", 64'(q.size()), 64'd0);
        repeat (3) begin
            tick();
            chk("idle_outs", outs, 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
